// File: rtl/uart_pkg.sv
// uart_pkg: FSM states, default addresses and status bit positions for mmio_uart_tx
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [31:0] txdata_addr_def = 32'hFFFF_FF00;
  localparam logic [31:0] status_addr_def = 32'hFFFF_FF04;
  localparam int st_full   = 0;
  localparam int st_empty  = 1;
  localparam int st_active = 2;
  localparam int st_ovf    = 3;
  localparam int st_par    = 4;
  localparam int st_cnt_lo = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO, push accepted when full if a pop happens at the same edge
module sync_fifo #(
  parameter int W = 8,
  parameter int D = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [$clog2(D):0] count
);
  localparam int aw = $clog2(D);
  logic [W-1:0] mem [D];
  logic [aw-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = count == (aw+1)'(D);
  assign empty   = count == '0;
  assign dout    = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + aw'(do_push);
      rp    <= rp + aw'(do_pop);
      count <= count + (aw+1)'(do_push) - (aw+1)'(do_pop);
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO 8N1 UART transmitter with byte FIFO; UART_TX_PARITY_EN adds an even parity bit
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TXDATA_ADDR  = txdata_addr_def,
  parameter logic [31:0] STATUS_ADDR  = status_addr_def
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);
  localparam int cw = $clog2(CLKS_PER_BIT);
  localparam int nw = $clog2(FIFO_DEPTH) + 1;
  localparam logic [cw-1:0] cnt_last = cw'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic par_en = 1'b1;
`else
  localparam logic par_en = 1'b0;
`endif
  state_t state, state_n;
  logic [cw-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, dout;
  logic [nw-1:0] count;
  logic [31:0] status;
  logic is_tx, is_st, push, pop, full, empty, ovf, last, tx_n, unused_bits;
  assign is_tx       = dataadr == TXDATA_ADDR;
  assign is_st       = dataadr == STATUS_ADDR;
  assign sel         = is_tx || is_st;
  assign push        = memwrite && is_tx;
  assign last        = cnt == cnt_last;
  assign busy        = !empty || state != IDLE;
  assign rdata       = is_st ? status : '0;
  assign unused_bits = ^writedata[31:8];
  sync_fifo #(.W(8), .D(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .push(push), .pop(pop), .din(writedata[7:0]),
    .dout(dout), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    status              = '0;
    status[st_full]     = full;
    status[st_empty]    = empty;
    status[st_active]   = state != IDLE;
    status[st_ovf]      = ovf;
    status[st_par]      = par_en;
    status[st_cnt_lo+:8] = 8'(count);
  end
  always_comb begin
    state_n = state;
    cnt_n   = last ? '0 : cnt + cw'(1);
    idx_n   = idx;
    sh_n    = sh;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = dout;
          state_n = START;
        end
      end
      START: if (last) begin
        state_n = DATA;
        idx_n   = '0;
      end
      DATA: if (last) begin
        if (idx == 3'd7) begin
          if (par_en) state_n = PARITY;
          else state_n = STOP;
        end else idx_n = idx + 3'd1;
      end
      PARITY: if (last) state_n = STOP;
      STOP: if (last) begin
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = dout;
          state_n = START;
        end else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[idx_n] : state_n == PARITY ? ^sh_n : 1'b1;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      tx    <= tx_n;
      if (push && full && !pop) ovf <= 1'b1;
      else if (memwrite && is_st) ovf <= 1'b0;
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the data-memory bus of the single-cycle MIPS system, downstream of the processor's store port. It snoops `memwrite`/`dataadr`/`writedata`, queues bytes stored to its TXDATA address in a small FIFO and serialises them 8N1 on `tx`. A status word is returned on `rdata` for loads from its STATUS address; the top level muxes it into `readdata` when `sel` is high.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, 8: byte entries; power of two, 2..128.
- `TXDATA_ADDR`, 32'hFFFF_FF00: store here pushes `writedata[7:0]`.
- `STATUS_ADDR`, 32'hFFFF_FF04: load returns status; any store here clears the overflow flag.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `memwrite` in 1: processor store strobe.
- `dataadr` in 32: processor data address.
- `writedata` in 32: processor store data.
- `sel` out 1: combinational; high when `dataadr` equals `TXDATA_ADDR` or `STATUS_ADDR`.
- `rdata` out 32: combinational status word when `dataadr == STATUS_ADDR`, else 0.
- `tx` out 1: serial line, registered, idle high.
- `busy` out 1: high when FIFO non-empty or FSM not IDLE.

## Operation
- Push: `memwrite && dataadr == TXDATA_ADDR` at an edge enqueues `writedata[7:0]`; upper bits are ignored.
- Push when full with no pop at the same edge: byte dropped, sticky `ovf` set. Push and pop at the same edge while full: push accepted, count unchanged.
- `memwrite && dataadr == STATUS_ADDR`: clears `ovf` (data ignored). If overflow occurs at the same edge, set wins.
- Status word:
  - bit0 `full`
  - bit1 `empty`
  - bit2 `active` (FSM ≠ IDLE)
  - bit3 `ovf`
  - [15:8] FIFO count
  - all other bits 0
- FSM states:
  - IDLE: `tx=1`. If FIFO non-empty: pop into shift register, go to START.
  - START: `tx=0` for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: 8 bits LSB first, each for `CLKS_PER_BIT` cycles. Bit index counts 0..7, then STOP (or PARITY when enabled).
  - STOP: `tx=1` for `CLKS_PER_BIT` cycles. On the last cycle, if the FIFO is non-empty, pop and go straight to START (no idle gap); else go to IDLE.
- Baud counter runs 0..`CLKS_PER_BIT-1`, resets to 0 on every state or bit change. Width is `$clog2(CLKS_PER_BIT)`.
- Loads have no side effects.

## Timing
- Reset values: `tx=1`, `busy=0`, FIFO empty (count 0), `ovf=0`, FSM IDLE, counters 0. `sel`/`rdata` are purely combinational.
- Reset asserted mid-frame aborts the frame: `tx` is 1 after the reset edge and queued bytes are discarded.
- Store captured at edge E0. Count and `busy` reflect it after E0.
- IDLE pops at E1; `tx` falls after E1. First-byte latency from store to start bit: 2 edges.
- Frame length: 10·`CLKS_PER_BIT` cycles (11· with parity). Back-to-back frames are contiguous.
- The status read in the cycle of a push shows the pre-push values.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state between DATA and STOP; transmits even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - Status bit4 reads 1.
- Undefined: 8N1 only, no PARITY state; bit4 reads 0.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - default address constants
  - status bit position constants
- Sub-module `sync_fifo`: parameterised width/depth, synchronous reset, push/pop/full/empty/count, same-edge push-and-pop when full allowed. `mmio_uart_tx` instantiates it with width 8.

## Test plan
Bench uses `CLKS_PER_BIT=4`, `FIFO_DEPTH=4`.
- Reset, then idle 20 cycles → `tx=1`, `busy=0`, `rdata` at STATUS = 32'h0000_0002.
- Store 32'hABCD_0055 to FF00 → start bit after 2 edges; `tx` per 4 cycles: 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop); 40-cycle frame; `busy` drops after stop.
- Store 0x41 then 0x42 back-to-back → second start bit immediately follows first stop bit; no idle cycle.
- Six consecutive stores while the first frame is in flight: one byte is popped, four are queued, one is dropped. Status shows count 4, full=1, ovf=1. A store to FF04 then clears ovf.
- Assert reset during data bit 3 of a frame → `tx=1` next cycle, count 0, no further transitions.
- With `UART_TX_PARITY_EN`: store 0x07 → parity bit 1, 44-cycle frame, status bit4=1.
